// File: rtl/led_pwm_driver.sv
// led_pwm_driver
//   Drives the physical LED pins from the active-low pattern of the memory-mapped LED register.
//   It adds PWM dimming and optional blinking, both under control of a local CTRL register.
//   The pattern and the duty are shadowed only at PWM frame boundaries, so a CPU store can
//   never change a frame part-way through.
//
// Parameters
//   PRESCALE      clk cycles per PWM tick (>=1); one PWM frame = 256*PRESCALE cycles
//   BLINK_FRAMES  PWM frames per blink half-period (>=1)
//
// Ports
//   clk          system clock, all state on posedge
//   reset_n      asynchronous reset, active-low
//   led_in       pattern from the LED register, active-low (0 = lit)
//   ctrl_we      CTRL write strobe from the bridge
//   ctrl_byteen  byte enables for a CTRL write
//   ctrl_wdata   CTRL write data
//   ctrl_rdata   CTRL readback: [7:0] duty, [8] blink_en, [16] enable, other bits 0
//   led_pin      LED pins, active-low (1 = dark), registered
//   frame_start  one-cycle pulse at the start of each PWM frame, registered
module led_pwm_driver #(
  parameter int unsigned PRESCALE     = 100,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] led_in,
  input  logic        ctrl_we,
  input  logic [3:0]  ctrl_byteen,
  input  logic [31:0] ctrl_wdata,
  output logic [31:0] ctrl_rdata,
  output logic [31:0] led_pin,
  output logic        frame_start
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BlW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);
  localparam logic [BlW-1:0] BlMax = BlW'(BLINK_FRAMES - 1);

  // CTRL register fields
  logic [7:0]     duty_q, duty_d;
  logic           blink_en_q, blink_en_d;
  logic           enable_q, enable_d;

  // Timebase
  logic [PsW-1:0] prescale_q, prescale_d;
  logic [7:0]     pwm_cnt_q, pwm_cnt_d;
  logic [BlW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  // Frame-boundary shadows
  logic [31:0]    pattern_q, pattern_d;
  logic [7:0]     duty_shadow_q, duty_shadow_d;

  // Registered outputs
  logic [31:0]    led_pin_q, led_pin_d;
  logic           frame_start_q, frame_start_d;

  logic tick;
  logic fb;
  logic blink_clr;
  logic pwm_on;
  logic blank;

  // Reserved CTRL bits and byte lane 3 carry no state.
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl_wdata[31:17], ctrl_wdata[15:9], ctrl_byteen[3]};

  assign ctrl_rdata  = {15'b0, enable_q, 7'b0, blink_en_q, duty_q};
  assign led_pin     = led_pin_q;
  assign frame_start = frame_start_q;

  always_comb begin
    tick = (prescale_q == PsMax);
    fb   = tick & (pwm_cnt_q == 8'hFF);

    prescale_d = tick ? '0 : prescale_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

    // Byte-lane writes into the implemented CTRL bits only.
    duty_d     = duty_q;
    blink_en_d = blink_en_q;
    enable_d   = enable_q;
    if (ctrl_we) begin
      if (ctrl_byteen[0]) duty_d     = ctrl_wdata[7:0];
      if (ctrl_byteen[1]) blink_en_d = ctrl_wdata[8];
      if (ctrl_byteen[2]) enable_d   = ctrl_wdata[16];
    end

    // Clearing blink_en restarts the blink sequence; it wins over a same-edge frame boundary.
    blink_clr     = ctrl_we & ctrl_byteen[1] & ~ctrl_wdata[8];
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (blink_clr) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (fb & blink_en_q) begin
      if (blink_cnt_q == BlMax) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Shadows take the CTRL value from before any same-edge write.
    pattern_d     = fb ? ~led_in : pattern_q;
    duty_shadow_d = fb ? duty_q : duty_shadow_q;

    pwm_on        = (duty_shadow_q == 8'hFF) | (pwm_cnt_q < duty_shadow_q);
    blank         = blink_en_q & blink_phase_q;
    led_pin_d     = ~(pattern_q & {32{pwm_on & enable_q & ~blank}});
    frame_start_d = fb;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q        <= 8'hFF;
      blink_en_q    <= 1'b0;
      enable_q      <= 1'b1;
      prescale_q    <= '0;
      pwm_cnt_q     <= 8'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pattern_q     <= 32'd0;
      duty_shadow_q <= 8'hFF;
      led_pin_q     <= 32'hFFFF_FFFF;
      frame_start_q <= 1'b0;
    end else begin
      duty_q        <= duty_d;
      blink_en_q    <= blink_en_d;
      enable_q      <= enable_d;
      prescale_q    <= prescale_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pattern_q     <= pattern_d;
      duty_shadow_q <= duty_shadow_d;
      led_pin_q     <= led_pin_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Testbench for led_pwm_driver: a scripted opening (defaults, duty write, blink, mid-frame
// pattern change, enable toggle) followed by random CTRL writes and pattern changes, with a
// mid-run asynchronous reset. Every cycle the outputs are compared against a behavioural
// model that derives the frame position arithmetically from the cycle count since reset.
module tb_led_pwm_driver;

  localparam int unsigned P     = 2;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 256 * P;
  localparam int          NCYC  = 24000;
  localparam int          RST_AT = 12000;

  logic        clk;
  logic        reset_n;
  logic [31:0] led_in;
  logic        ctrl_we;
  logic [3:0]  ctrl_byteen;
  logic [31:0] ctrl_wdata;
  logic [31:0] ctrl_rdata;
  logic [31:0] led_pin;
  logic        frame_start;

  led_pwm_driver #(
    .PRESCALE    (P),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .led_in     (led_in),
    .ctrl_we    (ctrl_we),
    .ctrl_byteen(ctrl_byteen),
    .ctrl_wdata (ctrl_wdata),
    .ctrl_rdata (ctrl_rdata),
    .led_pin    (led_pin),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: CTRL fields, shadows, and the number of blink-counted frames.
  int unsigned m_cyc;
  logic [7:0]  m_duty;
  logic        m_blink_en;
  logic        m_enable;
  logic [31:0] m_pattern;
  logic [7:0]  m_dutyq;
  int unsigned m_nfb;
  logic [31:0] m_led;
  logic        m_fs;

  function automatic logic [31:0] m_rdata();
    return {15'b0, m_enable, 7'b0, m_blink_en, m_duty};
  endfunction

  task automatic model_reset();
    m_cyc      = 0;
    m_duty     = 8'hFF;
    m_blink_en = 1'b0;
    m_enable   = 1'b1;
    m_pattern  = 32'd0;
    m_dutyq    = 8'hFF;
    m_nfb      = 0;
    m_led      = 32'hFFFF_FFFF;
    m_fs       = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit          fb;
    int unsigned pwm;
    bit          on;
    bit          blank;
    fb    = (m_cyc % FRAME) == FRAME - 1;
    pwm   = (m_cyc / P) % 256;
    on    = (m_dutyq == 8'hFF) || (pwm < int'(m_dutyq));
    blank = m_blink_en && (((m_nfb / BF) % 2) == 1);
    m_led = (on && m_enable && !blank) ? ~m_pattern : 32'hFFFF_FFFF;
    m_fs  = fb;
    if (fb) begin
      m_pattern = ~led_in;
      m_dutyq   = m_duty;
    end
    if (ctrl_we && ctrl_byteen[1] && !ctrl_wdata[8]) m_nfb = 0;
    else if (fb && m_blink_en) m_nfb++;
    if (ctrl_we) begin
      if (ctrl_byteen[0]) m_duty     = ctrl_wdata[7:0];
      if (ctrl_byteen[1]) m_blink_en = ctrl_wdata[8];
      if (ctrl_byteen[2]) m_enable   = ctrl_wdata[16];
    end
    m_cyc++;
  endtask

  task automatic do_write(input logic [3:0] be, input logic [31:0] wd);
    ctrl_we     = 1'b1;
    ctrl_byteen = be;
    ctrl_wdata  = wd;
  endtask

  task automatic random_write();
    logic [31:0] wd;
    logic [7:0]  d;
    case ($urandom_range(0, 4))
      0:       d = 8'h00;
      1:       d = 8'hFF;
      2:       d = 8'h40;
      3:       d = 8'h80;
      default: d = 8'($urandom);
    endcase
    wd       = $urandom;
    wd[7:0]  = d;
    wd[16]   = ($urandom_range(0, 3) != 0);
    do_write(4'($urandom), wd);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset_n     = 1'b0;
    led_in      = 32'hFFFF_FF00;
    ctrl_we     = 1'b0;
    ctrl_byteen = 4'h0;
    ctrl_wdata  = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NCYC; i++) begin
      check("led_pin", led_pin, m_led);
      check("frame_start", {31'b0, frame_start}, {31'b0, m_fs});
      check("ctrl_rdata", ctrl_rdata, m_rdata());

      if (i == RST_AT) begin
        ctrl_we = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_led_pin", led_pin, 32'hFFFF_FFFF);
        check("rst_ctrl_rdata", ctrl_rdata, 32'h0001_00FF);
        check("rst_frame_start", {31'b0, frame_start}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_led_pin", led_pin, 32'hFFFF_FFFF);
        check("rst_hold_frame_start", {31'b0, frame_start}, 32'd0);
        reset_n = 1'b1;
      end

      ctrl_we     = 1'b0;
      ctrl_byteen = 4'h0;
      ctrl_wdata  = 32'h0;
      if (i < 8000) begin
        case (i)
          1200: do_write(4'b0001, 32'h0000_0040);
          2300: do_write(4'b0010, 32'h0000_01AA);
          4700: led_in = 32'h0000_0000;
          6000: do_write(4'b0100, 32'h0000_0000);
          6300: do_write(4'b0100, 32'h0001_0000);
          7000: do_write(4'b0010, 32'h0000_0000);
          7500: do_write(4'b0000, 32'hFFFF_FFFF);
          default: ;
        endcase
        // Pattern change landing exactly on a frame-boundary cycle is captured.
        if (i == 7679) led_in = 32'h1234_5678;
      end else begin
        if ($urandom_range(0, 199) == 0) random_write();
        if ($urandom_range(0, 149) == 0) led_in = $urandom;
        if ((m_cyc % FRAME) == FRAME - 1 && $urandom_range(0, 3) == 0) led_in = $urandom;
      end

      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
